// File: rtl/seq_det_param.sv
// Parametrised serial sequence detector with a registered one-cycle match pulse.
// Optional saturating match counter is built when SEQ_DET_MATCH_CNT_EN is defined.
//
// state (k)       | meaning
// 0               | no pattern bits matched
// 1..SEQ_LEN-1    | first k bits of SEQ matched, waiting for bit k+1
module seq_det_param #(
    parameter int                 SEQ_LEN = 5,
    parameter logic [SEQ_LEN-1:0] SEQ     = 5'b10001,
    parameter int                 OVERLAP = 0,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             en,
    input  logic             clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_len
        $error("seq_det_param: SEQ_LEN must be in 2..16");
    end
    if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
        $error("seq_det_param: CNT_W must be in 1..16");
    end

    localparam int KW    = (SEQ_LEN > 2) ? $clog2(SEQ_LEN) : 1;
    localparam int DEPTH = 1 << KW;

    // KMP next state: longest prefix of SEQ that is a suffix of (prefix_k, b)
    function automatic int calc_next(input int k, input int b);
        logic [31:0] seqv;
        logic [31:0] cand;
        logic [31:0] mask;
        int          lmax;
        int          res;
        seqv = 32'(SEQ);
        cand = ((seqv >> (SEQ_LEN - k)) << 1) | 32'(b);
        lmax = (k + 1 < SEQ_LEN) ? k + 1 : SEQ_LEN - 1;
        res  = 0;
        for (int l = 1; l <= lmax; l++) begin
            mask = (32'd1 << l) - 32'd1;
            if ((cand & mask) == (seqv >> (SEQ_LEN - l)))
                res = l;
        end
        return res;
    endfunction

    function automatic int calc_border();
        logic [31:0] seqv;
        logic [31:0] mask;
        int          res;
        seqv = 32'(SEQ);
        res  = 0;
        for (int l = 1; l < SEQ_LEN; l++) begin
            mask = (32'd1 << l) - 32'd1;
            if ((seqv & mask) == (seqv >> (SEQ_LEN - l)))
                res = l;
        end
        return res;
    endfunction

    localparam logic [KW-1:0] LAST   = KW'(SEQ_LEN - 1);
    localparam logic [KW-1:0] BORDER = KW'(calc_border());

    logic [KW-1:0] tab0 [DEPTH];
    logic [KW-1:0] tab1 [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tab
        if (g < SEQ_LEN) begin : g_live
            assign tab0[g] = KW'(calc_next(g, 0));
            assign tab1[g] = KW'(calc_next(g, 1));
        end else begin : g_dead
            assign tab0[g] = '0;
            assign tab1[g] = '0;
        end
    end

    logic [KW-1:0] k;
    logic [KW-1:0] k_next;
    logic          out_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k   <= '0;
            out <= 1'b0;
        end else begin
            k   <= k_next;
            out <= out_next;
        end
    end

    always_comb begin
        k_next   = k;
        out_next = 1'b0;
        if (clr) begin
            k_next = '0;
        end else if (en) begin
            // Last pattern bit: the candidate equals SEQ exactly when in matches SEQ[0]
            if (k == LAST && in == SEQ[0]) begin
                out_next = 1'b1;
                k_next   = (OVERLAP != 0) ? BORDER : '0;
            end else begin
                k_next = in ? tab1[k] : tab0[k];
            end
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            match_cnt <= '0;
        else if (clr)
            match_cnt <= '0;
        else if (out_next && match_cnt != {CNT_W{1'b1}})
            match_cnt <= match_cnt + CNT_W'(1);
    end
`else
    assign match_cnt = '0;
`endif

endmodule
